// File: rtl/ac_pkg.sv
// rtl/ac_pkg.sv - shared constants and sample type for the codec I2S block
package ac_pkg;

  localparam int AC_DATA_WDT = 24;
  localparam int AC_SLOT_WDT = 32;
  localparam int AC_BCLK_DIV = 4;

  typedef logic signed [AC_DATA_WDT-1:0] ac_sample_t;

endpackage

// File: rtl/ac_i2s_timing.sv
// rtl/ac_i2s_timing.sv - bit/word clock generation and bit position counter
module ac_i2s_timing
  import ac_pkg::*;
#(
  parameter int SLOT_WDT = AC_SLOT_WDT,
  parameter int BCLK_DIV = AC_BCLK_DIV,
  parameter int BIT_W    = $clog2(2 * SLOT_WDT)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             bclk,
  output logic             lrck,
  output logic             fall_evt,
  output logic             rise_evt,
  output logic             frame_evt,
  output logic [BIT_W-1:0] bit_cnt
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE    = DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(2 * SLOT_WDT - 1);
  localparam logic [BIT_W-1:0] RIGHT_FIRST = BIT_W'(SLOT_WDT);

  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_nxt;

  // Strobes flag the clk edge on which the corresponding bit clock edge is produced.
  assign fall_evt  = (div_cnt == DIV_LAST);
  assign rise_evt  = (div_cnt == DIV_RISE);
  assign frame_evt = fall_evt && (bit_cnt == BIT_LAST);
  assign bit_nxt   = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      bclk    <= 1'b0;
      lrck    <= 1'b0;
    end else begin
      div_cnt <= fall_evt ? '0 : div_cnt + 1'b1;
      if (fall_evt) begin
        bclk    <= 1'b0;
        bit_cnt <= bit_nxt;
        lrck    <= (bit_nxt >= RIGHT_FIRST);
      end else if (rise_evt) begin
        bclk <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ac_i2s_master.sv
// rtl/ac_i2s_master.sv - I2S master: DAC serializer, ADC deserializer and frame tick
module ac_i2s_master
  import ac_pkg::*;
#(
  parameter int DATA_WDT = AC_DATA_WDT,
  parameter int SLOT_WDT = AC_SLOT_WDT,
  parameter int BCLK_DIV = AC_BCLK_DIV
) (
  input  logic                clk,
  input  logic                reset,
  output logic                acBclk,
  output logic                acLrck,
  output logic                acDacDat,
  input  logic                acAdcDat,
  output logic                acTick,
  output logic [DATA_WDT-1:0] acAdcDataL,
  output logic [DATA_WDT-1:0] acAdcDataR,
  input  logic [DATA_WDT-1:0] acDacDataL,
  input  logic [DATA_WDT-1:0] acDacDataR
);

  localparam int BIT_W = $clog2(2 * SLOT_WDT);
  localparam logic [BIT_W-1:0] P_DATA      = BIT_W'(DATA_WDT);
  localparam logic [BIT_W-1:0] P_SLOT      = BIT_W'(SLOT_WDT);
  localparam logic [BIT_W-1:0] P_SLOT_M1   = BIT_W'(SLOT_WDT - 1);
  localparam logic [BIT_W-1:0] P_SLOT_DATA = BIT_W'(SLOT_WDT + DATA_WDT);

  if (DATA_WDT < 1 || DATA_WDT > SLOT_WDT - 1) begin : g_bad_data_wdt
    $error("ac_i2s_master: DATA_WDT must be in 1..SLOT_WDT-1");
  end
  if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_bclk_div
    $error("ac_i2s_master: BCLK_DIV must be even and >= 2");
  end

  logic             fall_evt;
  logic             rise_evt;
  logic             frame_evt;
  logic [BIT_W-1:0] bit_cnt;

  ac_i2s_timing #(
    .SLOT_WDT(SLOT_WDT),
    .BCLK_DIV(BCLK_DIV),
    .BIT_W   (BIT_W)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .bclk     (acBclk),
    .lrck     (acLrck),
    .fall_evt (fall_evt),
    .rise_evt (rise_evt),
    .frame_evt(frame_evt),
    .bit_cnt  (bit_cnt)
  );

  logic [DATA_WDT-1:0] dac_sh_l;
  logic [DATA_WDT-1:0] dac_sh_r;
  logic [DATA_WDT-1:0] cap_l;
  logic [DATA_WDT-1:0] cap_r;
  logic                dac_l_win;
  logic                dac_r_win;
  logic                adc_l_win;
  logic                adc_r_win;

  // DAC windows look at bit_cnt before the falling edge advances it; ADC windows at the settled value.
  assign dac_l_win = (bit_cnt < P_DATA);
  assign dac_r_win = (bit_cnt >= P_SLOT) && (bit_cnt < P_SLOT_DATA);
  assign adc_l_win = (bit_cnt != '0) && (bit_cnt <= P_DATA);
  assign adc_r_win = (bit_cnt > P_SLOT) && (bit_cnt <= P_SLOT_DATA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acDacDat   <= 1'b0;
      acTick     <= 1'b0;
      acAdcDataL <= '0;
      acAdcDataR <= '0;
      dac_sh_l   <= '0;
      dac_sh_r   <= '0;
      cap_l      <= '0;
      cap_r      <= '0;
    end else begin
      if (frame_evt) begin
        acAdcDataL <= cap_l;
        acAdcDataR <= cap_r;
        dac_sh_l   <= acDacDataL;
        dac_sh_r   <= acDacDataR;
        acTick     <= 1'b1;
        acDacDat   <= 1'b0;
      end else if (fall_evt) begin
        if (bit_cnt == P_SLOT_M1) begin
          acTick <= 1'b0;
        end
        if (dac_l_win) begin
          acDacDat <= dac_sh_l[DATA_WDT-1];
          dac_sh_l <= dac_sh_l << 1;
        end else if (dac_r_win) begin
          acDacDat <= dac_sh_r[DATA_WDT-1];
          dac_sh_r <= dac_sh_r << 1;
        end else begin
          acDacDat <= 1'b0;
        end
      end
      if (rise_evt) begin
        if (adc_l_win) begin
          cap_l <= (cap_l << 1) | DATA_WDT'(acAdcDat);
        end else if (adc_r_win) begin
          cap_r <= (cap_r << 1) | DATA_WDT'(acAdcDat);
        end
      end
    end
  end

endmodule
